// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode->execute operand-fetch stage with valid/ready flow control.
//   Holds the 32-entry register file and resolves rs1/rs2 through a priority forwarding
//   network (source 0 is youngest and wins), then the write-back bypass, then the RF.
//   An instruction that reads a register whose selected forwarding source is still pending
//   (load-use) is held in decode and the stall is counted. JALR transfers raise a one-cycle
//   redirect with the target LSB cleared. The control bundle passes through untouched.
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid/in_ready               decode-side handshake
//   in_rs1/in_rs2/in_use_rs1/2      source registers and whether they are read
//   in_pc_for_a/in_imm_for_b        operand A/B muxing
//   in_pc/in_imm/in_jalr/in_rd/in_ctrl  instruction fields
//   flush                           kills in-flight and incoming instruction
//   wb_en/wb_rd/wb_data             RF write port (also bypassed same cycle)
//   fwd_valid/pending/rd/data       packed forwarding sources
//   out_valid/out_ready             execute-side handshake
//   out_a/out_b/out_rs2/out_pc/out_imm/out_rd/out_ctrl  registered execute bundle
//   redirect_valid/redirect_pc/ret  JALR redirect pulse
//   stall_cycles                    saturating hazard-stall counter
module operand_fetch_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic                    in_use_rs1,
  input  logic                    in_use_rs2,
  input  logic                    in_pc_for_a,
  input  logic                    in_imm_for_b,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_imm,
  input  logic                    in_jalr,
  input  logic [4:0]              in_rd,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic [4:0]              wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_a,
  output logic [XLEN-1:0]         out_b,
  output logic [XLEN-1:0]         out_rs2,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_rd,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    ret,
  output logic [CNT_W-1:0]        stall_cycles
);

  logic [XLEN-1:0]   r_rf [32];
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_a, r_out_b, r_out_rs2, r_out_pc, r_out_imm, r_redirect_pc;
  logic [4:0]        r_out_rd;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic              r_redirect_valid, r_ret;
  logic [CNT_W-1:0]  r_stall;

  logic [XLEN:0]     w_rs1_res, w_rs2_res;
  logic [XLEN-1:0]   w_rs1_val, w_rs2_val, w_a_val, w_b_val, w_target;
  logic              w_hazard, w_ready, w_xfer;

  // Returns {pending, value}. Sources are scanned oldest-first so the youngest match
  // (lowest index) is the last to overwrite the result.
  function automatic logic [XLEN:0] resolve(input logic [4:0] r, input logic [XLEN-1:0] rf_val);
    logic [XLEN:0] res;
    res = {1'b0, rf_val};
    if (wb_en && (wb_rd == r)) begin
      res = {1'b0, wb_data};
    end else begin
      res = res;
    end
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == r)) begin
        res = {fwd_pending[i], fwd_data[XLEN*i +: XLEN]};
      end else begin
        res = res;
      end
    end
    if (r == 5'd0) begin
      res = {(XLEN+1){1'b0}};
    end else begin
      res = res;
    end
    return res;
  endfunction

  // Operand resolution, hazard detection and handshake
  always_comb begin
    w_rs1_res = resolve(in_rs1, r_rf[in_rs1]);
    w_rs2_res = resolve(in_rs2, r_rf[in_rs2]);
    w_rs1_val = w_rs1_res[XLEN-1:0];
    w_rs2_val = w_rs2_res[XLEN-1:0];
    w_hazard  = in_valid & ((in_use_rs1 & w_rs1_res[XLEN]) | (in_use_rs2 & w_rs2_res[XLEN]));
    w_ready   = ~flush & ~w_hazard & (~r_out_valid | out_ready);
    w_xfer    = in_valid & w_ready;
    w_a_val   = in_pc_for_a ? in_pc : w_rs1_val;
    w_b_val   = in_imm_for_b ? in_imm : w_rs2_val;
    w_target  = w_a_val + in_imm;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) r_rf[k] <= {XLEN{1'b0}};
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end else begin
      r_rf[0] <= r_rf[0];
    end
  end

  // Execute-side pipeline register; flush dominates, stalled data holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid      <= 1'b0;
      r_out_a          <= {XLEN{1'b0}};
      r_out_b          <= {XLEN{1'b0}};
      r_out_rs2        <= {XLEN{1'b0}};
      r_out_pc         <= {XLEN{1'b0}};
      r_out_imm        <= {XLEN{1'b0}};
      r_out_rd         <= 5'd0;
      r_out_ctrl       <= {CTRL_W{1'b0}};
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= {XLEN{1'b0}};
      r_ret            <= 1'b0;
    end else if (flush) begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_ret            <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid      <= 1'b1;
      r_out_a          <= w_a_val;
      r_out_b          <= w_b_val;
      r_out_rs2        <= w_rs2_val;
      r_out_pc         <= in_pc;
      r_out_imm        <= in_imm;
      r_out_rd         <= in_rd;
      r_out_ctrl       <= in_ctrl;
      r_redirect_valid <= in_jalr;
      r_redirect_pc    <= {w_target[XLEN-1:1], 1'b0};
      r_ret            <= in_jalr & (in_rd == 5'd0);
    end else begin
      r_out_valid      <= r_out_valid & ~out_ready;
      r_redirect_valid <= 1'b0;
      r_ret            <= 1'b0;
    end
  end

  // Saturating count of hazard-stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= {CNT_W{1'b0}};
    end else if (w_hazard && !flush && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall <= r_stall;
    end
  end

  assign in_ready       = w_ready;
  assign out_valid      = r_out_valid;
  assign out_a          = r_out_a;
  assign out_b          = r_out_b;
  assign out_rs2        = r_out_rs2;
  assign out_pc         = r_out_pc;
  assign out_imm        = r_out_imm;
  assign out_rd         = r_out_rd;
  assign out_ctrl       = r_out_ctrl;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign ret            = r_ret;
  assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  localparam int XLEN = 32, NUM_FWD = 3, CTRL_W = 16, CNT_W = 16;

  logic clk = 1'b0, reset;
  logic in_valid, in_ready, in_use_rs1, in_use_rs2, in_pc_for_a, in_imm_for_b, in_jalr, flush;
  logic [4:0] in_rs1, in_rs2, in_rd, wb_rd, out_rd;
  logic [XLEN-1:0] in_pc, in_imm, wb_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic wb_en, out_valid, out_ready, redirect_valid, ret;
  logic [NUM_FWD-1:0] fwd_valid, fwd_pending;
  logic [5*NUM_FWD-1:0] fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic [XLEN-1:0] out_a, out_b, out_rs2, out_pc, out_imm, redirect_pc;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_pc_for_a(in_pc_for_a), .in_imm_for_b(in_imm_for_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_jalr(in_jalr), .in_rd(in_rd), .in_ctrl(in_ctrl), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rs2(out_rs2), .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ret(ret), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [4:0]  rs1;
    logic [2:0]  fv;
    logic        wb;
    logic [31:0] exp_a;
  } vec_t;
  vec_t vecs [7];

  // reference model state
  logic [XLEN-1:0]   m_rf [32];
  logic              m_valid, m_rv, m_ret;
  logic [XLEN-1:0]   m_a, m_b, m_rs2, m_pc, m_imm, m_rpc;
  logic [4:0]        m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_pc_for_a = 0; in_imm_for_b = 0; in_pc = 0; in_imm = 0; in_jalr = 0; in_rd = 0;
    in_ctrl = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1; #3; reset = 0;
    tick();
  endtask

  task automatic set_fwd(input int i, input logic v, input logic p, input logic [4:0] rd,
                         input logic [XLEN-1:0] d);
    fwd_valid[i] = v; fwd_pending[i] = p;
    fwd_rd[5*i +: 5] = rd; fwd_data[XLEN*i +: XLEN] = d;
  endtask

  // Spec-level operand lookup: first matching forwarding source in priority order,
  // else write-back bypass, else the model register file; x0 is always zero.
  function automatic void mres(input logic [4:0] r, output logic [XLEN-1:0] v, output logic p);
    bit found;
    found = 0; p = 0; v = m_rf[r];
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_valid[i] && fwd_rd[5*i +: 5] == r) begin
        found = 1; v = fwd_data[XLEN*i +: XLEN]; p = fwd_pending[i];
      end
    end
    if (!found && wb_en && wb_rd == r) v = wb_data;
    if (r == 0) begin v = 0; p = 0; end
  endfunction

  initial begin
    logic [XLEN-1:0] v1, v2, av;
    logic p1, p2, hz, rdy;

    idle(); reset = 1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_ret", ret, 0);
    chk("rst_ctrl", out_ctrl, 0);
    @(posedge clk); #1; reset = 0;

    // RF write then read, x0 write ignored
    wb_en = 1; wb_rd = 5; wb_data = 32'h1234;
    tick();
    wb_rd = 0; wb_data = 32'hFFFF;
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1;
    tick();
    chk("rf_valid", out_valid, 1);
    chk("rf_read_x5", out_a, 32'h1234);
    wb_en = 0; in_rs1 = 0;
    tick();
    chk("rf_read_x0", out_a, 0);

    // forwarding priority table
    vecs[0] = '{rs1: 5'd7, fv: 3'b111, wb: 1'b1, exp_a: 32'hA};
    vecs[1] = '{rs1: 5'd7, fv: 3'b110, wb: 1'b1, exp_a: 32'hB};
    vecs[2] = '{rs1: 5'd7, fv: 3'b010, wb: 1'b1, exp_a: 32'hC};
    vecs[3] = '{rs1: 5'd7, fv: 3'b000, wb: 1'b0, exp_a: 32'hC};
    vecs[4] = '{rs1: 5'd9, fv: 3'b010, wb: 1'b0, exp_a: 32'h99};
    vecs[5] = '{rs1: 5'd0, fv: 3'b111, wb: 1'b1, exp_a: 32'h0};
    vecs[6] = '{rs1: 5'd9, fv: 3'b000, wb: 1'b0, exp_a: 32'h0};
    idle();
    set_fwd(0, 1, 0, 7, 32'hA); set_fwd(1, 1, 0, 9, 32'h99); set_fwd(2, 1, 0, 7, 32'hB);
    wb_rd = 7; wb_data = 32'hC;
    for (int k = 0; k < 7; k++) begin
      fwd_valid = vecs[k].fv; wb_en = vecs[k].wb; in_rs1 = vecs[k].rs1;
      in_valid = 1; in_use_rs1 = 1;
      #1 chk($sformatf("prio_ready_%0d", k), in_ready, 1);
      tick();
      chk($sformatf("prio_valid_%0d", k), out_valid, 1);
      chk($sformatf("prio_a_%0d", k), out_a, vecs[k].exp_a);
    end

    // load-use hazard
    do_reset();
    set_fwd(0, 1, 1, 3, 32'h55AA);
    in_valid = 1; in_rs2 = 3; in_use_rs2 = 1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("lu_in_ready", in_ready, 0);
      tick();
      chk("lu_out_valid", out_valid, 0);
    end
    chk("lu_stall2", stall_cycles, 2);
    fwd_pending = 0;
    #1 chk("lu_release_ready", in_ready, 1);
    tick();
    chk("lu_out_valid_after", out_valid, 1);
    chk("lu_out_rs2", out_rs2, 32'h55AA);
    chk("lu_out_b", out_b, 32'h55AA);
    fwd_pending = 3'b001; in_use_rs2 = 0;
    #1 chk("lu_unused_ready", in_ready, 1);
    tick();
    chk("lu_unused_stall", stall_cycles, 2);

    // backpressure
    idle();
    in_valid = 1; in_pc = 32'h100; in_ctrl = 16'h1111;
    tick();
    in_pc = 32'h200; in_ctrl = 16'h2222; out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_pc_hold", out_pc, 32'h100);
      chk("bp_ctrl_hold", out_ctrl, 16'h1111);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_next_pc", out_pc, 32'h200);
    chk("bp_next_ctrl", out_ctrl, 16'h2222);

    // JALR redirect
    idle();
    wb_en = 1; wb_rd = 1; wb_data = 32'h1003;
    tick();
    wb_en = 0;
    in_valid = 1; in_jalr = 1; in_rs1 = 1; in_use_rs1 = 1; in_imm = 4; in_rd = 0;
    tick();
    chk("jalr_rv", redirect_valid, 1);
    chk("jalr_pc", redirect_pc, 32'h1006);
    chk("jalr_ret", ret, 1);
    in_valid = 0; in_jalr = 0;
    tick();
    chk("jalr_pulse_end", redirect_valid, 0);
    chk("jalr_ret_end", ret, 0);
    in_valid = 1; in_jalr = 1; in_rd = 1;
    tick();
    chk("jalr_rd1_rv", redirect_valid, 1);
    chk("jalr_rd1_ret", ret, 0);
    flush = 1;
    #1 chk("flush_ready", in_ready, 0);
    tick();
    chk("flush_rv", redirect_valid, 0);
    chk("flush_valid", out_valid, 0);

    // reset mid-stall
    idle();
    wb_en = 1; wb_rd = 5; wb_data = 32'h77; in_valid = 1; in_pc = 32'h300;
    tick();
    wb_en = 0; out_ready = 0; in_rs1 = 3; in_use_rs1 = 1;
    set_fwd(0, 1, 1, 3, 32'h1);
    tick(); tick();
    chk("mid_pre_valid", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_stall", stall_cycles, 0);
    @(posedge clk); #1; reset = 0;
    idle();
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1;
    tick();
    chk("mid_rf_cleared", out_a, 0);

    // randomized run against the reference model
    do_reset();
    for (int k = 0; k < 32; k++) m_rf[k] = 0;
    m_valid = 0; m_rv = 0; m_ret = 0; m_stall = 0;
    m_a = 0; m_b = 0; m_rs2 = 0; m_pc = 0; m_imm = 0; m_rpc = 0; m_rd = 0; m_ctrl = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
      in_pc_for_a = 1'($urandom); in_imm_for_b = 1'($urandom);
      in_pc = $urandom; in_imm = $urandom; in_jalr = ($urandom_range(0, 3) == 0);
      in_rd = 5'($urandom_range(0, 3)); in_ctrl = 16'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      wb_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      for (int i = 0; i < NUM_FWD; i++)
        set_fwd(i, 1'($urandom), ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);

      mres(in_rs1, v1, p1);
      mres(in_rs2, v2, p2);
      hz  = in_valid & ((in_use_rs1 & p1) | (in_use_rs2 & p2));
      rdy = !flush && !hz && (!m_valid || out_ready);
      #1 chk("rand_in_ready", in_ready, rdy);

      if (flush) begin
        m_valid = 0; m_rv = 0; m_ret = 0;
      end else if (in_valid && rdy) begin
        av = in_pc_for_a ? in_pc : v1;
        m_valid = 1; m_a = av; m_b = in_imm_for_b ? in_imm : v2; m_rs2 = v2;
        m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
        m_rv = in_jalr; m_ret = in_jalr && (in_rd == 0);
        m_rpc = (av + in_imm) & ~32'h1;
      end else begin
        if (out_ready) m_valid = 0;
        m_rv = 0; m_ret = 0;
      end
      if (hz && !flush && m_stall < 65535) m_stall++;
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;

      tick();
      chk("rand_out_valid", out_valid, m_valid);
      chk("rand_rv", redirect_valid, m_rv);
      chk("rand_ret", ret, m_ret);
      chk("rand_stall", stall_cycles, m_stall);
      if (m_valid) begin
        chk("rand_a", out_a, m_a);
        chk("rand_b", out_b, m_b);
        chk("rand_rs2", out_rs2, m_rs2);
        chk("rand_pc", out_pc, m_pc);
        chk("rand_imm", out_imm, m_imm);
        chk("rand_rd", out_rd, m_rd);
        chk("rand_ctrl", out_ctrl, m_ctrl);
      end
      if (m_rv) chk("rand_rpc", redirect_pc, m_rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
